// File: rtl/dii_package.sv
// Shared DII flit type and packet-length constants for the debug interconnect.
package dii_package;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        valid;
    } dii_flit;

    localparam int DII_MIN_PKT_LEN = 3;

endpackage

// File: rtl/osd_pkt_stage_ram.sv
// Packet buffer for osd_pkt_stage: one write port, asynchronous read.
module osd_pkt_stage_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/osd_pkt_stage.sv
// Store-and-forward DII packet stage; drops runt and oversize packets whole.
// Optional drop counter enabled by defining OSD_PKT_STAGE_DROPCNT_EN.
module osd_pkt_stage
    import dii_package::*;
#(
    parameter int MAX_PKT_LEN = 8,
    parameter int MIN_PKT_LEN = DII_MIN_PKT_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  dii_flit     flit_in,
    output logic        flit_in_ready,
    output dii_flit     flit_out,
    input  logic        flit_out_ready,
    output logic [15:0] drop_cnt
);

    localparam int PW = $clog2(MAX_PKT_LEN + 1);
    localparam int AW = $clog2(MAX_PKT_LEN);
    localparam logic [PW-1:0] MIN_LEN  = PW'(MIN_PKT_LEN);
    localparam logic [PW-1:0] MAX_LAST = PW'(MAX_PKT_LEN - 1);
    localparam logic [PW-1:0] ONE      = PW'(1);

    typedef enum logic [1:0] {FILL, DRAIN, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] len_q, len_d;
    logic [PW-1:0] wr_ptr_inc;
    logic          mem_we;
    logic          drop;
    logic          out_valid;
    logic          in_hs, out_hs;
    logic          rd_last;
    logic [15:0]   rd_data;

    osd_pkt_stage_ram #(
        .DEPTH (MAX_PKT_LEN),
        .AW    (AW),
        .WIDTH (16)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (flit_in.data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    // Outputs are gated by rst so nothing is accepted or emitted during reset.
    assign flit_in_ready = !rst && (state_q != DRAIN);
    assign out_valid     = !rst && (state_q == DRAIN);
    assign in_hs         = flit_in.valid && flit_in_ready;
    assign out_hs        = out_valid && flit_out_ready;
    assign wr_ptr_inc    = wr_ptr_q + ONE;
    assign rd_last       = (rd_ptr_q == len_q - ONE);

    assign flit_out.data  = rd_data;
    assign flit_out.last  = out_valid && rd_last;
    assign flit_out.valid = out_valid;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        mem_we   = 1'b0;
        drop     = 1'b0;
        unique case (state_q)
            FILL: begin
                if (in_hs) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_inc;
                    if (flit_in.last) begin
                        if (wr_ptr_inc >= MIN_LEN) begin
                            len_d   = wr_ptr_inc;
                            state_d = DRAIN;
                        end else begin
                            drop     = 1'b1;
                            wr_ptr_d = '0;
                        end
                    end else if (wr_ptr_q == MAX_LAST) begin
                        drop    = 1'b1;
                        state_d = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (in_hs && flit_in.last) begin
                    wr_ptr_d = '0;
                    state_d  = FILL;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    if (rd_last) begin
                        rd_ptr_d = '0;
                        wr_ptr_d = '0;
                        state_d  = FILL;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ONE;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
        end
    end

`ifdef OSD_PKT_STAGE_DROPCNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_osd_pkt_stage.sv
// Self-checking bench for osd_pkt_stage: directed scenarios plus random packets
// against a packet-level reference model (valid/invalid length, saturating drops).
module tb_osd_pkt_stage;
    import dii_package::*;

    localparam int MAXL = 8;
    localparam int MINL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    dii_flit     flit_in = '0;
    logic        flit_in_ready;
    dii_flit     flit_out;
    logic        flit_out_ready = 1'b0;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [15:0] sbuf [16];
    logic [15:0] pend [$];
    bit          rpat [$];
    bit          rand_ready = 1'b0;
    int          model_drops = 0;

    osd_pkt_stage #(
        .MAX_PKT_LEN (MAXL),
        .MIN_PKT_LEN (MINL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flit_in        (flit_in),
        .flit_in_ready  (flit_in_ready),
        .flit_out       (flit_out),
        .flit_out_ready (flit_out_ready),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_drop();
`ifdef OSD_PKT_STAGE_DROPCNT_EN
        return 16'(model_drops);
`else
        return 16'h0;
`endif
    endfunction

    task automatic set_rand(input int n);
        for (int i = 0; i < n; i++) sbuf[i] = 16'($urandom);
    endtask

    // Drive an n-flit packet starting at the current negedge; ends at a negedge.
    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) begin
            flit_in = {sbuf[i], (i == n - 1), 1'b1};
            chk("in_ready_fill", flit_in_ready, 1);
            chk("out_valid_fill", flit_out.valid, 0);
            @(negedge clk);
        end
        flit_in = '0;
        if (n >= MINL && n <= MAXL) begin
            pend.delete();
            for (int i = 0; i < n; i++) pend.push_back(sbuf[i]);
        end else begin
            model_drops = (model_drops >= 65535) ? 65535 : model_drops + 1;
        end
    endtask

    task automatic check_idle();
        chk("idle_valid", flit_out.valid, 0);
        chk("idle_in_ready", flit_in_ready, 1);
        chk("drop_cnt", drop_cnt, exp_drop());
    endtask

    task automatic drain();
        int idx = 0;
        int cyc = 0;
        bit r;
        while (idx < pend.size() && cyc < 200) begin
            chk("out_valid", flit_out.valid, 1);
            chk("out_data", flit_out.data, pend[idx]);
            chk("out_last", flit_out.last, (idx == pend.size() - 1));
            chk("in_ready_drain", flit_in_ready, 0);
            if (rpat.size() > 0) r = rpat.pop_front();
            else if (rand_ready) r = 1'($urandom);
            else r = 1'b1;
            flit_out_ready = r;
            @(negedge clk);
            if (r) idx++;
            cyc++;
        end
        chk("drain_timeout", idx, pend.size());
        flit_out_ready = 1'b0;
        pend.delete();
        check_idle();
    endtask

    task automatic send_and_check(input int n);
        send_pkt(n);
        if (pend.size() > 0) drain();
        else check_idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_in_ready", flit_in_ready, 0);
        chk("rst_valid", flit_out.valid, 0);
        @(negedge clk);
        chk("rst_valid2", flit_out.valid, 0);
        chk("rst_last", flit_out.last, 0);
        rst = 1'b0;
        pend.delete();
        model_drops = 0;
        #1;
        check_idle();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_in_ready", flit_in_ready, 0);
        chk("reset_valid", flit_out.valid, 0);
        do_reset();

        // 1: minimal legal packet, continuous drain
        sbuf[0] = 16'h0005; sbuf[1] = 16'h0001; sbuf[2] = 16'h4000;
        send_and_check(3);

        // 2: oversize then legal
        set_rand(10);
        send_and_check(10);
        chk("drop_after_oversize", drop_cnt, exp_drop());
        set_rand(3);
        send_and_check(3);

        // 3: runt then maximum-length packet
        sbuf[0] = 16'h0005; sbuf[1] = 16'h0001;
        send_and_check(2);
        set_rand(8);
        send_and_check(8);
        set_rand(9);
        send_and_check(9);
        set_rand(1);
        send_and_check(1);

        // 4: stalled drain
        set_rand(4);
        rpat = '{1, 0, 0, 1, 0, 1, 1};
        send_and_check(4);

        // 5: reset mid-fill, then mid-drain
        set_rand(2);
        for (int i = 0; i < 2; i++) begin
            flit_in = {sbuf[i], 1'b0, 1'b1};
            @(negedge clk);
        end
        flit_in = '0;
        do_reset();
        set_rand(4);
        send_pkt(4);
        chk("mid_valid", flit_out.valid, 1);
        chk("mid_data", flit_out.data, pend[0]);
        flit_out_ready = 1'b1;
        @(negedge clk);
        do_reset();
        flit_out_ready = 1'b0;
        set_rand(3);
        send_and_check(3);

        // 6: drop counter saturation
`ifdef OSD_PKT_STAGE_DROPCNT_EN
        force dut.drop_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.drop_cnt_q;
        model_drops = 16'hFFFE;
        chk("forced_cnt", drop_cnt, 16'hFFFE);
`endif
        for (int k = 0; k < 3; k++) begin
            set_rand(2);
            send_and_check(2);
        end
        chk("sat_cnt", drop_cnt, exp_drop());

        // Random packets, random downstream backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            int n;
            n = int'($urandom_range(1, 11));
            set_rand(n);
            send_and_check(n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
